// File: rtl/dct_pkg.sv
// dct_pkg: shared sizes and coefficient type for the row/column DCT transpose path
package dct_pkg;
    localparam int N    = 16;
    localparam int W    = 11;
    localparam int IDXW = $clog2(N);
    localparam int BUSW = N * W;
    typedef logic signed [W-1:0] coef_t;
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: NxN coefficient store, row-write port, combinational column-read port
// Ports: clk, rstn (async clear); we/wr_row/wr_data write one row; rd_col selects the column on rd_data.
module transpose_bank
    import dct_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            we,
    input  logic [IDXW-1:0] wr_row,
    input  logic [BUSW-1:0] wr_data,
    input  logic [IDXW-1:0] rd_col,
    output logic [BUSW-1:0] rd_data
);
    coef_t mem_q [N][N];
    coef_t mem_d [N][N];

    always_comb begin
        mem_d = mem_q;
        if (we)
            for (int c = 0; c < N; c++)
                mem_d[wr_row][c] = coef_t'(wr_data[c*W +: W]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem_q[r][c] <= '0;
        else
            mem_q <= mem_d;
    end

    // Element k of the column bus is row k of the selected column.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++)
            rd_data[k*W +: W] = mem_q[k][rd_col];
    end
endmodule

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 16x16 transpose buffer between row DCT and column DCT
// Ports: clk, rstn (async, active-low); in_valid/in_ready/in_data accept one row per cycle;
// out_valid/out_ready/out_data emit one column per cycle with its index out_col and block-end flag out_last.
module dct_transpose_buf
    import dct_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BUSW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BUSW-1:0] out_data,
    output logic [IDXW-1:0] out_col,
    output logic            out_last
);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IDXW-1:0] wr_row_q, wr_row_d, rd_col_q, rd_col_d;
    logic [BUSW-1:0] col0, col1;
    logic            wr_fire, rd_fire;

    // Both handshake sides depend only on registered flags, so there is no in/out combinational path.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_data  = rd_bank_q ? col1 : col0;
    assign out_col   = rd_col_q;
    assign out_last  = out_valid && rd_col_q == LAST;

    // The writer only targets an empty bank and the reader only a full one, so set and clear never collide.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        if (wr_fire) begin
            wr_row_d = wr_row_q == LAST ? '0 : wr_row_q + 1'b1;
            if (wr_row_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_col_d = rd_col_q == LAST ? '0 : rd_col_q + 1'b1;
            if (rd_col_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
        end
    end

    transpose_bank u_bank0 (
        .clk     (clk),
        .rstn    (rstn),
        .we      (wr_fire && !wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (in_data),
        .rd_col  (rd_col_q),
        .rd_data (col0)
    );

    transpose_bank u_bank1 (
        .clk     (clk),
        .rstn    (rstn),
        .we      (wr_fire && wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (in_data),
        .rd_col  (rd_col_q),
        .rd_data (col1)
    );
endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: randomized self-checking bench against a queue-of-rows reference model
module tb_dct_transpose_buf;
    import dct_pkg::*;

    typedef logic [W-1:0] row_t [N];

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [BUSW-1:0] in_data = '0;
    logic            in_ready, out_valid, out_last;
    logic [BUSW-1:0] out_data;
    logic [IDXW-1:0] out_col;

    row_t rows_q[$];
    int   rd_c;
    int   n_checks;
    int   n_fail;
    int   acc_rows;
    int   acc_cols;

    always #5 clk = ~clk;

    dct_transpose_buf dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    // Model: rows stored but not yet fully read out; a block is readable once 16 rows exist,
    // and the buffer holds at most two blocks.
    function automatic logic exp_ready();
        return rows_q.size() < 2 * N;
    endfunction

    function automatic logic exp_valid();
        return rows_q.size() >= N;
    endfunction

    function automatic logic [BUSW-1:0] exp_col();
        logic [BUSW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = rows_q[k][rd_c];
        return v;
    endfunction

    function automatic logic [BUSW-1:0] pack(input row_t r);
        logic [BUSW-1:0] v = '0;
        for (int c = 0; c < N; c++) v[c*W +: W] = r[c];
        return v;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < N; c++) r[c] = W'($urandom);
        return r;
    endfunction

    // Drives one cycle of inputs (called just after a falling edge) and advances the model
    // by the handshakes that will happen at the next rising edge.
    task automatic drive(input logic iv, input row_t r, input logic ordy);
        logic wf, rf;
        wf = iv && exp_ready();
        rf = exp_valid() && ordy;
        in_valid  = iv;
        in_data   = pack(r);
        out_ready = ordy;
        if (rf) begin
            acc_cols++;
            rd_c++;
            if (rd_c == N) begin
                for (int i = 0; i < N; i++) void'(rows_q.pop_front());
                rd_c = 0;
            end
        end
        if (wf) begin
            rows_q.push_back(r);
            acc_rows++;
        end
    endtask

    task automatic model_clear();
        rows_q.delete();
        rd_c = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_col !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b vld=%b data=%h col=%0d last=%b, want 1 0 0 0 0", in_ready, out_valid, out_data, out_col, out_last);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_col !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b data=%h col=%0d last=%b, want 1 0 0 0 0", in_ready, out_valid, out_data, out_col, out_last);
        end
        model_clear();
    endtask

    task automatic test_single_block();
        row_t r;
        int   c0 = acc_cols;
        int   sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid() || out_last !== (exp_valid() && rd_c == N - 1)) begin
                n_fail++;
                $display("FAIL single_hs cyc%0d: rdy=%b vld=%b last=%b, want %b %b %b", cyc, in_ready, out_valid, out_last, exp_ready(), exp_valid(), exp_valid() && rd_c == N - 1);
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== IDXW'(rd_c)) begin
                    n_fail++;
                    $display("FAIL single_col cyc%0d: col=%0d data=%h, want col=%0d data=%h", cyc, out_col, out_data, rd_c, exp_col());
                end
            end
            // Latency: the 16th row was accepted at the edge ending cycle 15, so cycle 16 shows column 0.
            if (cyc == 15 || cyc == 16) begin
                n_checks++;
                if (out_valid !== (cyc == 16)) begin
                    n_fail++;
                    $display("FAIL single_latency cyc%0d: vld=%b want %b", cyc, out_valid, cyc == 16);
                end
            end
            for (int c = 0; c < N; c++) r[c] = W'(sent * 16 + c);
            drive(sent < N, r, 1'b1);
            if (sent < N) sent++;
        end
        n_checks++;
        if (acc_cols - c0 != N || rows_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: cols=%0d left=%0d, want 16 0", acc_cols - c0, rows_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int first_rd = -1, last_rd = -1, r0 = acc_rows, sent = 0;
        for (int cyc = 0; cyc < 52; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid() || out_last !== (exp_valid() && rd_c == N - 1)) begin
                n_fail++;
                $display("FAIL b2b_hs cyc%0d: rdy=%b vld=%b last=%b, want %b %b %b", cyc, in_ready, out_valid, out_last, exp_ready(), exp_valid(), exp_valid() && rd_c == N - 1);
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== IDXW'(rd_c)) begin
                    n_fail++;
                    $display("FAIL b2b_col cyc%0d: col=%0d data=%h, want col=%0d data=%h", cyc, out_col, out_data, rd_c, exp_col());
                end
            end
            if (out_valid === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (sent < 2 * N && in_ready === 1'b1) sent++;
            drive(sent <= 2 * N && cyc < 2 * N, rand_row(), 1'b1);
        end
        n_checks++;
        if (acc_rows - r0 != 2 * N || first_rd != N || last_rd != 3 * N - 1) begin
            n_fail++;
            $display("FAIL b2b_bubbles: rows=%0d first=%0d last=%0d, want 32 16 47", acc_rows - r0, first_rd, last_rd);
        end
    endtask

    task automatic test_backpressure();
        int r0 = acc_rows;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid()) begin
                n_fail++;
                $display("FAIL bp_hs cyc%0d: rdy=%b vld=%b, want %b %b", cyc, in_ready, out_valid, exp_ready(), exp_valid());
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== '0) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc%0d: col=%0d data=%h, want col=0 data=%h", cyc, out_col, out_data, exp_col());
                end
            end
            drive(1'b1, rand_row(), 1'b0);
        end
        @(negedge clk);
        n_checks++;
        if (acc_rows - r0 != 2 * N || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: rows=%0d rdy=%b, want 32 0", acc_rows - r0, in_ready);
        end
        for (int cyc = 0; cyc < 3 * N; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == N) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_release: rdy=%b want 1 after 16 columns", in_ready);
                end
            end
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid()) begin
                n_fail++;
                $display("FAIL bp_drain_hs cyc%0d: rdy=%b vld=%b, want %b %b", cyc, in_ready, out_valid, exp_ready(), exp_valid());
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== IDXW'(rd_c) || out_last !== (rd_c == N - 1)) begin
                    n_fail++;
                    $display("FAIL bp_drain_col cyc%0d: col=%0d data=%h last=%b, want col=%0d data=%h", cyc, out_col, out_data, out_last, rd_c, exp_col());
                end
            end
            drive(1'b0, rand_row(), 1'b1);
        end
    endtask

    task automatic test_signed();
        row_t r;
        int   sent = 0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            @(negedge clk);
            if (exp_valid()) begin
                n_checks++;
                if (out_data[W-1:0] !== 11'h400 || out_data[2*W-1:W] !== 11'h3FF || out_data !== exp_col()) begin
                    n_fail++;
                    $display("FAIL signed_col cyc%0d: e0=%h e1=%h data=%h, want e0=400 e1=3ff data=%h", cyc, out_data[W-1:0], out_data[2*W-1:W], out_data, exp_col());
                end
            end
            r = rand_row();
            if (sent < 2)
                for (int c = 0; c < N; c++) r[c] = sent == 0 ? 11'h400 : 11'h3FF;
            drive(sent < N, r, 1'b1);
            if (sent < N) sent++;
        end
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        for (int cyc = 0; cyc < N + 7; cyc++) begin
            @(negedge clk);
            drive(1'b1, rand_row(), 1'b0);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: vld=%b want 1", out_valid);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_col !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b data=%h col=%0d last=%b, want 1 0 0 0 0", in_ready, out_valid, out_data, out_col, out_last);
        end
        model_clear();
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid()) begin
                n_fail++;
                $display("FAIL mid_hs cyc%0d: rdy=%b vld=%b, want %b %b", cyc, in_ready, out_valid, exp_ready(), exp_valid());
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== IDXW'(rd_c)) begin
                    n_fail++;
                    $display("FAIL mid_col cyc%0d: col=%0d data=%h, want col=%0d data=%h", cyc, out_col, out_data, rd_c, exp_col());
                end
            end
            drive(sent < N, rand_row(), 1'b1);
            if (sent < N) sent++;
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid() || out_last !== (exp_valid() && rd_c == N - 1)) begin
                n_fail++;
                $display("FAIL rand_hs cyc%0d: rdy=%b vld=%b last=%b, want %b %b %b", cyc, in_ready, out_valid, out_last, exp_ready(), exp_valid(), exp_valid() && rd_c == N - 1);
            end
            if (exp_valid()) begin
                n_checks++;
                if (out_data !== exp_col() || out_col !== IDXW'(rd_c)) begin
                    n_fail++;
                    $display("FAIL rand_col cyc%0d: col=%0d data=%h, want col=%0d data=%h", cyc, out_col, out_data, rd_c, exp_col());
                end
            end
            drive(cyc < 300 && $urandom_range(3) != 0, rand_row(), cyc >= 300 || $urandom_range(2) != 0);
        end
        n_checks++;
        if (rows_q.size() >= N) begin
            n_fail++;
            $display("FAIL rand_drain: %0d rows still pending, want < 16", rows_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        acc_rows = 0;
        acc_cols = 0;
        rd_c     = 0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_signed();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
Ping-pong 16x16 transpose memory between the row (first-pass) 1-D DCT and the column DCT (DCT_col) inside the 2-D DCT datapath. It accepts one row of 16 row-DCT coefficients per cycle and emits one column of 16 coefficients per cycle to the column DCT. Two banks let the writer fill one block while the reader drains the other, sustaining one row per cycle in and one column per cycle out.

Parameters:
N, 16, points per 1-D transform: rows per block and coefficients per row.
W, 11, width of each signed coefficient (matches the 176-bit, 16x11 row-DCT output bus).

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
in_valid  input  1  in_data holds a valid row.
in_ready  output  1  buffer can accept a row this cycle.
in_data  input  N*W  row r; element c at bits [c*W +: W], c=0 at LSB; two's complement.
out_valid  output  1  out_data holds a valid column.
out_ready  input  1  column DCT accepts this cycle.
out_data  output  N*W  column c; element k = stored row k, col c, at bits [k*W +: W].
out_col  output  log2(N)  index c of the column on out_data.
out_last  output  1  high with the final column (c = N-1) of a block.

Behaviour:
- Clock and reset: single clock domain clk; reset rstn is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_col=0, out_last=0; both bank_full flags=0; wr_bank=0, rd_bank=0, wr_row=0, rd_col=0; all storage cleared to 0.
- Write handshake: a row is accepted when in_valid && in_ready at a rising edge; stored in bank[wr_bank] row wr_row; wr_row increments.
- On the accept with wr_row=N-1: bank_full[wr_bank] set, wr_bank toggles, wr_row wraps to 0.
- in_ready = !bank_full[wr_bank], derived from registered state only (no combinational path from out_ready).
- Read side: out_valid = bank_full[rd_bank]. out_data = column rd_col of bank[rd_bank], driven from registered storage; out_col = rd_col; out_last = out_valid && rd_col==N-1.
- Read handshake: out_valid && out_ready advances rd_col. On the handshake at rd_col=N-1: bank_full[rd_bank] cleared, rd_bank toggles, rd_col wraps to 0.
- out_data/out_col stay stable while out_valid && !out_ready.
- Latency: first column valid the cycle after the Nth row is accepted (1 cycle).
- Throughput: with in_valid and out_ready held high, zero bubbles in steady state. The clear of bank_full at the edge of the last column read makes in_ready=1 for that bank on the following cycle.
- Simultaneous set/clear of the same bank flag cannot occur: the writer only targets a non-full bank, the reader only a full bank. Write and read of different banks in the same cycle are independent.
- Both banks full: in_ready=0 until the reader completes a block.
- Data passes unmodified: no rounding or saturation; sign is preserved bit-exact.
- Reset mid-block: partial rows and columns are discarded, all state returns to reset values, and the next accepted row is row 0 of bank 0.

Decomposition:
- Shared package dct_pkg: N, W, index width IDXW=$clog2(N), the coefficient typedef (signed [W-1:0]), and the row-bus width N*W.
- Sub-module transpose_bank: one NxN register array with a row-write port (we, row index, row bus) and a combinational column-read port (column index to column bus), async reset clear. Instantiate it twice.
- Top level holds the pointers, full flags and handshake logic.

Test Plan:
- Reset -> in_ready=1, out_valid=0, out_data=0 while rstn=0 and on the first cycle after release.
- One block, rows in[r][c]=r*16+c, out_ready=1 -> out_valid rises 1 cycle after row 15; column c element k = k*16+c; out_col counts 0..15; out_last only at c=15.
- Two back-to-back blocks, in_valid=1, out_ready=1 continuously -> 32 rows and 32 columns with no idle cycles on either side after the first block; second block read from bank 1.
- Backpressure, out_ready=0 -> exactly 32 rows accepted, then in_ready=0; out_data holds column 0 of block 0. Raise out_ready -> 16 columns, then in_ready=1.
- Signed extremes: row 0 all 11'h400 (-1024), row 1 all 11'h3FF (+1023) -> each column shows element0=11'h400 and element1=11'h3FF bit-exact.
- Reset asserted after 7 rows of a block -> outputs return to reset values immediately; a new 16-row block then reads out correctly from bank 0 with no residue from the aborted rows.
